mem_access_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline; sits between EX/MEM and MEM_WB.
- Executes loads and stores over a req/ack data-memory port with variable latency, and stalls the upstream pipeline while an access is outstanding.
- Passes non-memory instructions straight through to MEM_WB.
- Flags misaligned or illegal accesses and memory timeouts.

---
 rtl/mem_stage_pkg.sv | 18 +
 rtl/mem_timeout_ctr.sv | 36 +++
 rtl/mem_access_stage.sv | 167 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MIPS MEM stage.
package mem_stage_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned CTR_WIDTH      = 8;

    localparam int unsigned MEMREAD  = 1;
    localparam int unsigned MEMWRITE = 0;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for an outstanding memory access; hit_c flags the last allowed cycle.
module mem_timeout_ctr
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit_c
);

    logic [CTR_WIDTH-1:0] count_q;
    logic [CTR_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CTR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit_c = (count_q == CTR_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs loads/stores over a req/ack port, stalls upstream while busy.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            i_WB,
    input  logic [1:0]            i_M,
    input  logic [DATA_WIDTH-1:0] i_alures,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_stall,
    output logic [1:0]            o_WB,
    output logic [DATA_WIDTH-1:0] o_dataread,
    output logic [DATA_WIDTH-1:0] o_alures,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  o_err
);

    mem_state_e            state_q, state_d;
    logic [1:0]            wb_q, wb_d;
    logic [DATA_WIDTH-1:0] alures_q, alures_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  aborted_q, aborted_d;
    logic                  err_q, err_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic                  stall_c;
    logic [1:0]            wb_c;
    logic [DATA_WIDTH-1:0] dataread_c;
    logic [DATA_WIDTH-1:0] alures_c;
    logic                  ctr_clr;
    logic                  ctr_en;
    logic                  ctr_hit_c;
    logic                  illegal_c;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clk   (clk),
        .rst_n (rst),
        .clr   (ctr_clr),
        .en    (ctr_en),
        .hit_c (ctr_hit_c)
    );

    assign illegal_c = (i_M[MEMREAD] & i_M[MEMWRITE]) |
                       ((i_alures[1:0] & ALIGN_MASK) != 2'b00);

    always_comb begin
        state_d     = state_q;
        wb_d        = wb_q;
        alures_d    = alures_q;
        we_d        = we_q;
        rdata_d     = rdata_q;
        aborted_d   = aborted_q;
        err_d       = err_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        stall_c     = 1'b0;
        wb_c        = 2'b00;
        dataread_c  = '0;
        alures_c    = alures_q;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                alures_c = i_alures;
                if (i_M == 2'b00) begin
                    wb_c = i_WB;
                end else if (illegal_c) begin
                    err_d = 1'b1;
                end else begin
                    stall_c     = 1'b1;
                    wb_d        = i_WB;
                    alures_d    = i_alures;
                    we_d        = i_M[MEMWRITE];
                    aborted_d   = 1'b0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = i_M[MEMWRITE];
                    mem_addr_d  = {i_alures[DATA_WIDTH-1:2], 2'b00};
                    mem_wdata_d = i_wdata;
                    ctr_clr     = 1'b1;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall_c = 1'b1;
                ctr_en  = 1'b1;
                // An ack on the timeout cycle still counts as a normal completion.
                if (mem_ack) begin
                    rdata_d   = we_q ? '0 : mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (ctr_hit_c) begin
                    rdata_d   = '0;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!aborted_q) begin
                    wb_c       = wb_q;
                    dataread_c = rdata_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wb_q        <= 2'b00;
            alures_q    <= '0;
            we_q        <= 1'b0;
            rdata_q     <= '0;
            aborted_q   <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wb_q        <= wb_d;
            alures_q    <= alures_d;
            we_q        <= we_d;
            rdata_q     <= rdata_d;
            aborted_q   <= aborted_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Pipeline-facing outputs are held low for the whole time reset is asserted.
    assign o_stall    = rst & stall_c;
    assign o_WB       = rst ? wb_c : 2'b00;
    assign o_dataread = rst ? dataread_c : '0;
    assign o_alures   = rst ? alures_c : '0;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: IDLE vector table plus multi-cycle memory sequences.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  i_WB;
    logic [1:0]  i_M;
    logic [31:0] i_alures;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic [1:0]  o_WB;
    logic [31:0] o_dataread;
    logic [31:0] o_alures;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_WB       (i_WB),
        .i_M        (i_M),
        .i_alures   (i_alures),
        .i_wdata    (i_wdata),
        .o_stall    (o_stall),
        .o_WB       (o_WB),
        .o_dataread (o_dataread),
        .o_alures   (o_alures),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [1:0]  m;
        logic [1:0]  wb;
        logic [31:0] addr;
        logic [1:0]  exp_wb;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply_vec(input int i);
        @(negedge clk);
        i_M      = vecs[i].m;
        i_WB     = vecs[i].wb;
        i_alures = vecs[i].addr;
        i_wdata  = 32'hCAFE_0000;
        #1;
        chk({vecs[i].name, " o_WB"},       32'(o_WB),       32'(vecs[i].exp_wb));
        chk({vecs[i].name, " o_alures"},   o_alures,        vecs[i].addr);
        chk({vecs[i].name, " o_dataread"}, o_dataread,      32'h0);
        chk({vecs[i].name, " o_stall"},    32'(o_stall),    32'h0);
        @(posedge clk);
        #1;
        chk({vecs[i].name, " mem_req"},    32'(mem_req),    32'h0);
        chk({vecs[i].name, " o_err"},      32'(o_err),      32'(vecs[i].exp_err));
    endtask

    task automatic mem_op(input string nm, input logic [1:0] m, input logic [1:0] wb,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ack_at,
                          input logic [1:0] exp_wb, input logic [31:0] exp_data,
                          input int exp_busy);
        int stalls = 0;
        int busy   = 0;
        bit stable = 1'b1;
        bit done   = 1'b0;
        @(negedge clk);
        i_M      = m;
        i_WB     = wb;
        i_alures = addr;
        i_wdata  = wdata;
        mem_ack  = 1'b0;
        #1;
        chk({nm, " issue stall"},  32'(o_stall), 32'h1);
        chk({nm, " issue bubble"}, 32'(o_WB),    32'h0);
        if (o_stall) stalls++;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (mem_req) begin
                if (mem_addr !== addr || mem_wdata !== wdata || mem_we !== m[0]) stable = 1'b0;
                mem_ack   = (busy == ack_at);
                mem_rdata = mem_ack ? rdata : 32'hBAD0_BAD0;
                busy++;
                #1;
                if (o_stall) stalls++;
                if (o_WB !== 2'b00) stable = 1'b0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'h0;
                #1;
                chk({nm, " done stall"},    32'(o_stall), 32'h0);
                chk({nm, " done o_WB"},     32'(o_WB),    32'(exp_wb));
                chk({nm, " done dataread"}, o_dataread,   exp_data);
                chk({nm, " done alures"},   o_alures,     addr);
                done = 1'b1;
            end
        end
        mem_ack = 1'b0;
        chk({nm, " done reached"},  32'(done),   32'h1);
        chk({nm, " busy cycles"},   32'(busy),   32'(exp_busy));
        chk({nm, " stall cycles"},  32'(stalls), 32'(exp_busy + 1));
        chk({nm, " req stable"},    32'(stable), 32'h1);
        @(negedge clk);
        i_M = 2'b00;
    endtask

    initial begin
        vecs[0] = '{"pass44",   2'b00, 2'b10, 32'h0000_0044, 2'b10, 1'b0};
        vecs[1] = '{"pass103",  2'b00, 2'b01, 32'h0000_0103, 2'b01, 1'b0};
        vecs[2] = '{"passtop",  2'b00, 2'b11, 32'hFFFF_FFFC, 2'b11, 1'b0};
        vecs[3] = '{"misalign", 2'b10, 2'b11, 32'h0000_0102, 2'b00, 1'b1};
        vecs[4] = '{"rdwr",     2'b11, 2'b10, 32'h0000_0100, 2'b00, 1'b1};
        vecs[5] = '{"st_mis",   2'b01, 2'b01, 32'h0000_0201, 2'b00, 1'b1};
        vecs[6] = '{"sticky",   2'b00, 2'b10, 32'h0000_0008, 2'b10, 1'b1};

        rst = 1'b0; i_WB = 2'b11; i_M = 2'b00; i_alures = 32'hFF; i_wdata = 32'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        #1;
        chk("reset o_WB",     32'(o_WB),    32'h0);
        chk("reset o_alures", o_alures,     32'h0);
        chk("reset o_stall",  32'(o_stall), 32'h0);
        chk("reset mem_req",  32'(mem_req), 32'h0);
        chk("reset mem_addr", mem_addr,     32'h0);
        chk("reset o_err",    32'(o_err),   32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 3; i++) apply_vec(i);

        mem_op("load0", 2'b10, 2'b11, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0,
               2'b11, 32'hDEAD_BEEF, 1);
        mem_op("store3", 2'b01, 2'b10, 32'h0000_0200, 32'h1234_5678, 32'h5555_AAAA, 3,
               2'b10, 32'h0, 4);
        chk("no err after ops", 32'(o_err), 32'h0);

        mem_op("timeout", 2'b10, 2'b01, 32'h0000_0300, 32'h0, 32'h0, -1,
               2'b00, 32'h0, 4);
        chk("timeout err", 32'(o_err), 32'h1);

        // Late ack while idle must not disturb the pass-through path.
        i_WB = 2'b01; i_alures = 32'h0000_0010; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        #1;
        chk("late ack o_WB",     32'(o_WB),    32'h1);
        chk("late ack dataread", o_dataread,   32'h0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        chk("late ack mem_req",  32'(mem_req), 32'h0);
        chk("late ack o_stall",  32'(o_stall), 32'h0);
        chk("late ack o_WB2",    32'(o_WB),    32'h1);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset clears err", 32'(o_err), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 3; i < 7; i++) apply_vec(i);

        @(negedge clk);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        chk("err cleared again", 32'(o_err), 32'h0);

        // Reset in the middle of an outstanding load.
        @(negedge clk);
        i_M = 2'b10; i_WB = 2'b11; i_alures = 32'h0000_0400; mem_ack = 1'b0;
        @(negedge clk);
        #1;
        chk("midbusy req up",   32'(mem_req), 32'h1);
        chk("midbusy stall up", 32'(o_stall), 32'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("midbusy req drop",   32'(mem_req), 32'h0);
        chk("midbusy stall drop", 32'(o_stall), 32'h0);
        chk("midbusy o_WB",       32'(o_WB),    32'h0);
        chk("midbusy o_alures",   o_alures,     32'h0);
        chk("midbusy dataread",   o_dataread,   32'h0);
        @(negedge clk);
        i_M = 2'b00; i_WB = 2'b10; i_alures = 32'h0000_0044;
        rst = 1'b1;
        #1;
        chk("post reset o_WB",     32'(o_WB),    32'h2);
        chk("post reset o_alures", o_alures,     32'h44);
        chk("post reset o_stall",  32'(o_stall), 32'h0);
        @(posedge clk);
        #1;
        chk("post reset mem_req",  32'(mem_req), 32'h0);
        chk("post reset o_WB2",    32'(o_WB),    32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
